// File: rtl/rgb_pixel_assembler.sv
// Packs an R,G,B byte stream into 24-bit pixels tagged with x/y position and
// line/frame markers, held in an output register under a valid/ready handshake.
module rgb_pixel_assembler #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int X_W        = 10,
   parameter int Y_W        = 9
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic [7:0]     byte_in,
   input  logic           byte_valid,
   output logic           byte_ready,
   output logic [23:0]    rgb_pixel,
   output logic           pix_valid,
   input  logic           pix_ready,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           sol,
   output logic           eol,
   output logic           sof,
   output logic           eof,
   output logic           frame_done
);

   localparam logic [1:0] PH_R = 2'd0;
   localparam logic [1:0] PH_G = 2'd1;
   localparam logic [1:0] PH_B = 2'd2;

   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

   logic [1:0]     ph_q, ph_d;
   logic [7:0]     r_q, r_d;
   logic [7:0]     g_q, g_d;
   logic [X_W-1:0] xc_q, xc_d;
   logic [Y_W-1:0] yc_q, yc_d;

   logic [23:0]    pix_q, pix_d;
   logic           pix_valid_q, pix_valid_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           sol_q, sol_d;
   logic           eol_q, eol_d;
   logic           sof_q, sof_d;
   logic           eof_q, eof_d;
   logic           frame_done_q, frame_done_d;

   logic accept;
   logic b_accept;
   logic consume;

   // B may only enter when the output slot is empty or draining this cycle.
   assign byte_ready = rst_n && !flush && (ph_q != PH_B || !pix_valid_q || pix_ready);
   assign accept     = byte_valid && byte_ready;
   assign b_accept   = accept && (ph_q == PH_B);
   assign consume    = pix_valid_q && pix_ready;

   always_comb begin
      // NOTE: every signal takes its hold value first so no path through the
      // case/if tree leaves it unassigned and infers a latch.
      ph_d = ph_q;
      r_d  = r_q;
      g_d  = g_q;
      xc_d = xc_q;
      yc_d = yc_q;
      if (flush) begin
         ph_d = PH_R;
         xc_d = '0;
         yc_d = '0;
      end else if (accept) begin
         case (ph_q)
            PH_R: begin
               r_d  = byte_in;
               ph_d = PH_G;
            end
            PH_G: begin
               g_d  = byte_in;
               ph_d = PH_B;
            end
            default: begin
               ph_d = PH_R;
               if (xc_q == X_LAST) begin
                  xc_d = '0;
                  yc_d = (yc_q == Y_LAST) ? '0 : yc_q + 1'b1;
               end else begin
                  xc_d = xc_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      pix_d        = pix_q;
      pix_valid_d  = pix_valid_q;
      x_d          = x_q;
      y_d          = y_q;
      sol_d        = sol_q;
      eol_d        = eol_q;
      sof_d        = sof_q;
      eof_d        = eof_q;
      frame_done_d = consume && eof_q;
      // A new pixel replaces a consumed one without a bubble.
      if (b_accept) begin
         pix_d       = {r_q, g_q, byte_in};
         pix_valid_d = 1'b1;
         x_d         = xc_q;
         y_d         = yc_q;
         sol_d       = (xc_q == '0);
         eol_d       = (xc_q == X_LAST);
         sof_d       = (xc_q == '0) && (yc_q == '0);
         eof_d       = (xc_q == X_LAST) && (yc_q == Y_LAST);
      end else if (consume) begin
         pix_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the R/G staging bytes are reset along with everything else so
         // no stale partial pixel survives a reset.
         ph_q         <= PH_R;
         r_q          <= '0;
         g_q          <= '0;
         xc_q         <= '0;
         yc_q         <= '0;
         pix_q        <= '0;
         pix_valid_q  <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         sol_q        <= 1'b0;
         eol_q        <= 1'b0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         ph_q         <= ph_d;
         r_q          <= r_d;
         g_q          <= g_d;
         xc_q         <= xc_d;
         yc_q         <= yc_d;
         pix_q        <= pix_d;
         pix_valid_q  <= pix_valid_d;
         x_q          <= x_d;
         y_q          <= y_d;
         sol_q        <= sol_d;
         eol_q        <= eol_d;
         sof_q        <= sof_d;
         eof_q        <= eof_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign rgb_pixel  = pix_q;
   assign pix_valid  = pix_valid_q;
   assign x          = x_q;
   assign y          = y_q;
   assign sol        = sol_q;
   assign eol        = eol_q;
   assign sof        = sof_q;
   assign eof        = eof_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_pixel_assembler.sv
// Self-checking bench for rgb_pixel_assembler on a 4x2 frame: directed steps
// followed by a randomized three-frame run against a transaction-level model.
module tb_rgb_pixel_assembler;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int X_W = 2;
   localparam int Y_W = 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flush;
   logic [7:0]     byte_in;
   logic           byte_valid;
   logic           byte_ready;
   logic [23:0]    rgb_pixel;
   logic           pix_valid;
   logic           pix_ready;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           sol, eol, sof, eof;
   logic           frame_done;

   rgb_pixel_assembler #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .X_W       (X_W),
      .Y_W       (Y_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .byte_in   (byte_in),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .rgb_pixel (rgb_pixel),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .x         (x),
      .y         (y),
      .sol       (sol),
      .eol       (eol),
      .sof       (sof),
      .eof       (eof),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: byte count within the pixel, pixel index within the frame, held pixel.
   int          m_ph;
   int          m_k;
   logic [7:0]  m_r, m_g;
   logic        m_valid;
   logic [23:0] m_pix;
   int          m_x, m_y;
   logic        m_sol, m_eol, m_sof, m_eof;
   logic        m_fd;

   int          fd_seen;
   logic        last_acc;
   logic [23:0] consumed[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_k = 0; m_r = '0; m_g = '0;
      m_valid = 1'b0; m_pix = '0; m_x = 0; m_y = 0;
      m_sol = 1'b0; m_eol = 1'b0; m_sof = 1'b0; m_eof = 1'b0; m_fd = 1'b0;
   endtask

   task automatic check_outputs();
      check("pix_valid", pix_valid, m_valid);
      check("rgb_pixel", rgb_pixel, m_pix);
      check("x", x, m_x);
      check("y", y, m_y);
      check("sol", sol, m_sol);
      check("eol", eol, m_eol);
      check("sof", sof, m_sof);
      check("eof", eof, m_eof);
      check("frame_done", frame_done, m_fd);
      if (frame_done === 1'b1) fd_seen++;
   endtask

   // One clock cycle: check held state, drive inputs, predict the handshake,
   // then advance the model across the rising edge.
   task automatic step(input logic bv, input logic [7:0] b, input logic pr, input logic fl);
      logic exp_ready, acc, cons;
      @(negedge clk);
      check_outputs();
      byte_valid = bv; byte_in = b; pix_ready = pr; flush = fl;
      #1;
      exp_ready = !fl && (m_ph != 2 || !m_valid || pr);
      check("byte_ready", byte_ready, exp_ready);
      acc  = bv && exp_ready;
      cons = m_valid && pr;
      last_acc = acc;
      if (cons) consumed.push_back(rgb_pixel);
      @(posedge clk);
      m_fd = cons && m_eof;
      if (cons) m_valid = 1'b0;
      if (fl) begin
         m_ph = 0;
         m_k  = 0;
      end else if (acc) begin
         if (m_ph == 0) m_r = b;
         else if (m_ph == 1) m_g = b;
         else begin
            m_pix   = {m_r, m_g, b};
            m_valid = 1'b1;
            m_x     = m_k % W;
            m_y     = m_k / W;
            m_sol   = (m_x == 0);
            m_eol   = (m_x == W - 1);
            m_sof   = m_sol && (m_y == 0);
            m_eof   = m_eol && (m_y == H - 1);
            m_k     = (m_k + 1) % (W * H);
         end
         m_ph = (m_ph + 1) % 3;
      end
   endtask

   logic [7:0] stream[72];
   int         idx;
   int         cyc;

   initial begin
      rst_n = 1'b0; flush = 1'b0; byte_in = '0; byte_valid = 1'b0; pix_ready = 1'b0;
      model_reset();
      fd_seen = 0;
      last_acc = 1'b0;

      // Reset values.
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_byte_ready", byte_ready, 1'b0);
      check_outputs();
      rst_n = 1'b1;
      #1;
      check("rel_byte_ready", byte_ready, 1'b1);

      // First pixel 0x112233.
      step(1'b1, 8'h11, 1'b1, 1'b0);
      step(1'b1, 8'h22, 1'b1, 1'b0);
      step(1'b1, 8'h33, 1'b1, 1'b0);
      #1;
      check("t1_rgb", rgb_pixel, 24'h112233);
      check("t1_valid", pix_valid, 1'b1);
      check("t1_sof", sof, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      check("t1_valid_drop", pix_valid, 1'b0);

      // Full 4x2 frame continuously, then pixel 9 starts the next frame.
      step(1'b0, 8'h00, 1'b1, 1'b1);
      fd_seen = 0;
      for (int p = 0; p < 9; p++)
         for (int i = 0; i < 3; i++)
            step(1'b1, 8'(p * 3 + i + 1), 1'b1, 1'b0);
      #1;
      check("t2_fd_pulses", fd_seen, 1);
      check("t2_p9_x", x, 0);
      check("t2_p9_y", y, 0);
      check("t2_p9_sof", sof, 1'b1);

      // Backpressure: R/G stage while the output is held, B stalls.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h41, 1'b0, 1'b0);
      step(1'b1, 8'h42, 1'b0, 1'b0);
      step(1'b1, 8'h43, 1'b0, 1'b0);
      step(1'b1, 8'h51, 1'b0, 1'b0);
      step(1'b1, 8'h52, 1'b0, 1'b0);
      step(1'b1, 8'h53, 1'b0, 1'b0);
      step(1'b1, 8'h53, 1'b0, 1'b0);
      #1;
      check("t3_stall_ready", byte_ready, 1'b0);
      check("t3_hold_rgb", rgb_pixel, 24'h414243);
      step(1'b1, 8'h53, 1'b1, 1'b0);
      #1;
      check("t3_nobubble_rgb", rgb_pixel, 24'h515253);
      check("t3_nobubble_valid", pix_valid, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush with R and G staged.
      step(1'b1, 8'h61, 1'b1, 1'b0);
      step(1'b1, 8'h62, 1'b1, 1'b0);
      step(1'b1, 8'h63, 1'b1, 1'b1);
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      step(1'b1, 8'hBB, 1'b1, 1'b0);
      step(1'b1, 8'hCC, 1'b1, 1'b0);
      #1;
      check("t4_rgb", rgb_pixel, 24'hAABBCC);
      check("t4_x", x, 0);
      check("t4_sof", sof, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset with a held pixel at x=1.
      step(1'b1, 8'h71, 1'b0, 1'b0);
      step(1'b1, 8'h72, 1'b0, 1'b0);
      step(1'b1, 8'h73, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_valid", pix_valid, 1'b0);
      check("t5_rgb", rgb_pixel, 24'h0);
      check("t5_x", x, 0);
      check("t5_flags", {sol, eol, sof, eof}, 4'b0000);
      check("t5_ready", byte_ready, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h81, 1'b1, 1'b0);
      step(1'b1, 8'h82, 1'b1, 1'b0);
      step(1'b1, 8'h83, 1'b1, 1'b0);
      #1;
      check("t5_post_x", x, 0);
      check("t5_post_y", y, 0);
      check("t5_post_rgb", rgb_pixel, 24'h818283);

      // Random gaps over three frames.
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 72; i++) stream[i] = 8'($urandom_range(0, 255));
      consumed.delete();
      fd_seen = 0;
      idx = 0;
      cyc = 0;
      while ((consumed.size() < 24 || m_valid) && cyc < 3000) begin
         step((idx < 72) && ($urandom_range(0, 3) != 0), stream[(idx < 72) ? idx : 0],
              $urandom_range(0, 2) != 0, 1'b0);
         if (last_acc) idx++;
         cyc++;
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("rand_within_budget", cyc < 3000, 1'b1);
      check("rand_count", consumed.size(), 24);
      for (int p = 0; p < 24; p++) begin
         if (p < consumed.size())
            check("rand_pixel", consumed[p], {stream[3 * p], stream[3 * p + 1], stream[3 * p + 2]});
      end
      check("rand_frame_done", fd_seen, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
